// File: rtl/data_mem_responder.sv
// data_mem_responder: backing memory behind the data-cache miss port.
// Fixed-latency single-word writes and LINE_WORDS-beat line reads.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_we, req_addr,       1 = write; byte address (word index in
//   req_wdata                 [AW+1:2]); write data
//   resp_valid, resp_rdata, one beat per cycle, no backpressure;
//   resp_last, resp_err       rdata is 0 on write acks and error beats
//
// Option: define MEM_RESP_ERR_EN to flag out-of-range or misaligned
//   addresses on resp_err (no storage access) instead of wrapping.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 3,
   parameter int LINE_WORDS  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_last,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
   localparam logic [3:0]    LAT_LOAD  = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      WRITE,
      READ
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    lat_cnt;
   logic [3:0]    lat_next;
   logic [BW-1:0] beat;
   logic [BW-1:0] beat_next;

   logic          held_we;
   logic [AW-1:0] held_idx;
   logic [31:0]   held_wdata;
   logic          held_err;

   logic          valid_next;
   logic          last_next;
   logic          err_next;
   logic [31:0]   rdata_next;
   logic          mem_write;

   logic          accept;
   logic          addr_bad;
   logic [AW-1:0] line_base;

   logic [31:0]   mem [DEPTH_WORDS];

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign line_base = held_idx & ~LINE_MASK;

`ifdef MEM_RESP_ERR_EN
   assign addr_bad = (req_addr >= 32'(4 * DEPTH_WORDS))
                   || (req_addr[1:0] != 2'b00);
`else
   // Upper bits and byte offset are ignored: the index simply wraps.
   logic unused_addr;
   assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
   assign addr_bad    = 1'b0;
`endif

   // Request capture; the bus may change freely once accepted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         held_we    <= 1'b0;
         held_idx   <= '0;
         held_wdata <= '0;
         held_err   <= 1'b0;
      end else if (accept) begin
         held_we    <= req_we;
         held_idx   <= req_addr[AW+1:2];
         held_wdata <= req_wdata;
         held_err   <= addr_bad;
      end
   end

   // Next-state and next-beat logic. Response outputs are computed
   // here and registered, so the first beat appears on the edge that
   // leaves WAIT, exactly LATENCY edges after the accept edge.
   always_comb begin
      state_next = state;
      lat_next   = lat_cnt;
      beat_next  = beat;
      valid_next = 1'b0;
      last_next  = 1'b0;
      err_next   = 1'b0;
      rdata_next = '0;
      mem_write  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_next = WAIT;
               lat_next   = LAT_LOAD;
            end
         end
         WAIT: begin
            if (lat_cnt != 4'd0) begin
               lat_next = lat_cnt - 4'd1;
            end else if (held_we) begin
               // Storage updates on the ack edge, before IDLE.
               state_next = WRITE;
               valid_next = 1'b1;
               last_next  = 1'b1;
               err_next   = held_err;
               mem_write  = !held_err;
            end else begin
               state_next = READ;
               beat_next  = '0;
               valid_next = 1'b1;
               last_next  = (LINE_WORDS == 1);
               err_next   = held_err;
               rdata_next = held_err ? '0 : mem[line_base];
            end
         end
         WRITE: begin
            state_next = IDLE;
         end
         READ: begin
            if (beat == LAST_BEAT) begin
               state_next = IDLE;
               beat_next  = '0;
            end else begin
               beat_next  = beat + BW'(1);
               valid_next = 1'b1;
               last_next  = (beat_next == LAST_BEAT);
               err_next   = held_err;
               // OR is safe: the offset never carries out of the line.
               rdata_next = held_err ? '0
                          : mem[line_base | AW'(beat_next)];
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         beat       <= '0;
         resp_valid <= 1'b0;
         resp_last  <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state      <= state_next;
         lat_cnt    <= lat_next;
         beat       <= beat_next;
         resp_valid <= valid_next;
         resp_last  <= last_next;
         resp_err   <= err_next;
         resp_rdata <= rdata_next;
      end
   end

   // Storage is not reset; contents survive a reset.
   always_ff @(posedge clock) begin
      if (mem_write) begin
         mem[held_idx] <= held_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized bench against a word-array model.
// Three instances cover LATENCY/LINE_WORDS = 3/1, 3/4 and 1/2.
module tb_data_mem_responder;

   localparam int N     = 3;
   localparam int DEPTH = 256;
   localparam int MAXC  = 20;
   localparam int LAT [N] = '{3, 3, 1};
   localparam int LW  [N] = '{1, 4, 2};

`ifdef MEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
   } op_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_we;
   logic [N-1:0][31:0] req_addr;
   logic [N-1:0][31:0] req_wdata;
   wire  [N-1:0]       req_ready;
   wire  [N-1:0]       resp_valid;
   wire  [N-1:0][31:0] resp_rdata;
   wire  [N-1:0]       resp_last;
   wire  [N-1:0]       resp_err;

   int checks = 0;
   int errors = 0;

   bit [31:0] mdl   [N][DEPTH];
   bit        known [N][DEPTH];

   logic        ov   [MAXC];
   logic        ol   [MAXC];
   logic        oe   [MAXC];
   logic        ordy [MAXC];
   logic [31:0] ord  [MAXC];

   op_t ops [$];

   always #5 clock = ~clock;

   data_mem_responder #(
      .DEPTH_WORDS(256), .LATENCY(3), .LINE_WORDS(1)
   ) u0 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_last(resp_last[0]),
      .resp_err(resp_err[0])
   );

   data_mem_responder #(
      .DEPTH_WORDS(256), .LATENCY(3), .LINE_WORDS(4)
   ) u1 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_last(resp_last[1]),
      .resp_err(resp_err[1])
   );

   data_mem_responder #(
      .DEPTH_WORDS(256), .LATENCY(1), .LINE_WORDS(2)
   ) u2 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
      .resp_rdata(resp_rdata[2]), .resp_last(resp_last[2]),
      .resp_err(resp_err[2])
   );

   function automatic bit bad_addr(input logic [31:0] a);
      return ERR_EN && (a >= 32'(4 * DEPTH) || a[1:0] != 2'b00);
   endfunction

   function automatic void model_write(input int k,
                                       input logic [31:0] a,
                                       input logic [31:0] d);
      int idx;
      idx = int'((a >> 2) % DEPTH);
      if (!bad_addr(a)) begin
         mdl[k][idx]   = d;
         known[k][idx] = 1'b1;
      end
   endfunction

   // Expected outputs c cycles after an accept edge, for a lone request.
   function automatic void expect_at(
      input  int k, input bit we, input logic [31:0] a, input int c,
      output logic v, output logic l, output logic r, output logic e,
      output logic [31:0] d, output bit dk);
      int n, b, idx, base;
      n    = we ? 1 : LW[k];
      b    = c - LAT[k];
      idx  = int'((a >> 2) % DEPTH);
      base = idx - (idx % LW[k]);
      v    = (b >= 0) && (b < n);
      l    = v && (b == n - 1);
      r    = (c >= LAT[k] + n);
      e    = v && bad_addr(a);
      d    = 32'h0;
      dk   = 1'b1;
      if (v && !we && !bad_addr(a)) begin
         d  = mdl[k][base + b];
         dk = known[k][base + b];
      end
   endfunction

   // Issue one request on instance k and record MAXC cycles of outputs.
   // With hold, req_valid stays high and the bus switches to the second
   // request right after the accept, so it is taken as soon as possible.
   task automatic drive(input int k, input bit we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, input bit we2,
                        input logic [31:0] a2, input logic [31:0] wd2);
      int w;
      w = 0;
      @(negedge clock);
      while (req_ready[k] !== 1'b1 && w < 50) begin
         @(negedge clock);
         w++;
      end
      if (req_ready[k] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout inst%0d: ready=%b want 1",
                  k, req_ready[k]);
      end
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = a;
      req_wdata[k] = wd;
      @(posedge clock);
      for (int c = 0; c < MAXC; c++) begin
         @(negedge clock);
         ov[c]   = resp_valid[k];
         ol[c]   = resp_last[k];
         oe[c]   = resp_err[k];
         ordy[c] = req_ready[k];
         ord[c]  = resp_rdata[k];
         if (c == 0 && !hold) req_valid[k] = 1'b0;
         if (c == 0 && hold) begin
            req_we[k]    = we2;
            req_addr[k]  = a2;
            req_wdata[k] = wd2;
         end
         if (hold && c > 0 && ordy[c-1] === 1'b1) req_valid[k] = 1'b0;
      end
      req_valid[k] = 1'b0;
   endtask

   task automatic add_random(input int n);
      op_t o;
      for (int i = 0; i < n; i++) begin
         o.we   = 1'($urandom_range(0, 1));
         o.addr = 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 3) == 0) o.addr += 32'h400;
         if ($urandom_range(0, 3) == 0)
            o.addr += 32'($urandom_range(1, 3));
         o.wd = $urandom;
         ops.push_back(o);
      end
   endtask

   task automatic test_reset;
      int w;
      repeat (2) @(negedge clock);
      for (int k = 0; k < N; k++) begin
         checks++;
         if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 ||
             resp_last[k] !== 1'b0 || resp_err[k] !== 1'b0 ||
             resp_rdata[k] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state inst%0d: rdy=%b v=%b l=%b e=%b d=%h want 1 0 0 0 0",
                     k, req_ready[k], resp_valid[k], resp_last[k],
                     resp_err[k], resp_rdata[k]);
         end
      end
      reset = 1'b1;
      @(negedge clock);
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 32'h100;
      @(negedge clock);
      req_valid[1] = 1'b0;
      w = 0;
      while (resp_valid[1] !== 1'b1 && w < 20) begin
         @(negedge clock);
         w++;
      end
      checks++;
      if (resp_valid[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_beat: v=%b want 1", resp_valid[1]);
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1 ||
          resp_last[1] !== 1'b0 || resp_rdata[1] !== 32'h0) begin
         errors++;
         $display("FAIL reset_abort: v=%b rdy=%b l=%b d=%h want 0 1 0 0",
                  resp_valid[1], req_ready[1], resp_last[1],
                  resp_rdata[1]);
      end
      @(negedge clock);
      reset = 1'b1;
      drive(1, 1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
      model_write(1, 32'h100, 32'h11);
      checks++;
      if (ov[2] !== 1'b0 || ov[3] !== 1'b1 || ol[3] !== 1'b1 ||
          ov[4] !== 1'b0 || ordy[4] !== 1'b1) begin
         errors++;
         $display("FAIL reset_reaccept: v2=%b v3=%b l3=%b v4=%b rdy4=%b want 0 1 1 0 1",
                  ov[2], ov[3], ol[3], ov[4], ordy[4]);
      end
   endtask

   task automatic test_write_read;
      logic ev, el, er, ee;
      logic [31:0] ed;
      bit dk;
      ops.delete();
      ops.push_back('{1'b1, 32'h40, 32'hDEADBEEF});
      ops.push_back('{1'b0, 32'h40, 32'h0});
      add_random(30);
      foreach (ops[i]) begin
         drive(0, ops[i].we, ops[i].addr, ops[i].wd,
               1'b0, 1'b0, 32'h0, 32'h0);
         if (ops[i].we) model_write(0, ops[i].addr, ops[i].wd);
         for (int c = 0; c < MAXC; c++) begin
            expect_at(0, ops[i].we, ops[i].addr, c, ev, el, er, ee, ed, dk);
            checks++;
            if (ov[c] !== ev || ol[c] !== el || ordy[c] !== er ||
                oe[c] !== ee || (dk && ord[c] !== ed)) begin
               errors++;
               $display("FAIL write_read op%0d c%0d: got v%b l%b rdy%b e%b d=%h want v%b l%b rdy%b e%b d=%h",
                        i, c, ov[c], ol[c], ordy[c], oe[c], ord[c],
                        ev, el, er, ee, ed);
            end
         end
      end
   endtask

   task automatic test_burst;
      logic ev, el, er, ee;
      logic [31:0] ed;
      bit dk;
      ops.delete();
      ops.push_back('{1'b1, 32'h100, 32'h11});
      ops.push_back('{1'b1, 32'h104, 32'h22});
      ops.push_back('{1'b1, 32'h108, 32'h33});
      ops.push_back('{1'b1, 32'h10C, 32'h44});
      ops.push_back('{1'b0, 32'h108, 32'h0});
      add_random(30);
      foreach (ops[i]) begin
         drive(1, ops[i].we, ops[i].addr, ops[i].wd,
               1'b0, 1'b0, 32'h0, 32'h0);
         if (ops[i].we) model_write(1, ops[i].addr, ops[i].wd);
         for (int c = 0; c < MAXC; c++) begin
            expect_at(1, ops[i].we, ops[i].addr, c, ev, el, er, ee, ed, dk);
            checks++;
            if (ov[c] !== ev || ol[c] !== el || ordy[c] !== er ||
                oe[c] !== ee || (dk && ord[c] !== ed)) begin
               errors++;
               $display("FAIL burst op%0d c%0d: got v%b l%b rdy%b e%b d=%h want v%b l%b rdy%b e%b d=%h",
                        i, c, ov[c], ol[c], ordy[c], oe[c], ord[c],
                        ev, el, er, ee, ed);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic ev, el, er, ee;
      logic [31:0] ed;
      bit dk, w1;
      int k, off;
      logic [31:0] a1, a2, d1;
      for (int s = 0; s < 2; s++) begin
         k  = (s == 0) ? 0 : 1;
         w1 = (s == 0);
         a1 = (s == 0) ? 32'h80 : 32'h10C;
         a2 = (s == 0) ? 32'h80 : 32'h100;
         d1 = $urandom;
         drive(k, w1, a1, d1, 1'b1, 1'b0, a2, 32'h0);
         if (w1) model_write(k, a1, d1);
         off = LAT[k] + (w1 ? 1 : LW[k]) + 1;
         for (int c = 0; c < MAXC; c++) begin
            if (c < off)
               expect_at(k, w1, a1, c, ev, el, er, ee, ed, dk);
            else
               expect_at(k, 1'b0, a2, c - off, ev, el, er, ee, ed, dk);
            checks++;
            if (ov[c] !== ev || ol[c] !== el || ordy[c] !== er ||
                oe[c] !== ee || (dk && ord[c] !== ed)) begin
               errors++;
               $display("FAIL back_to_back s%0d c%0d: got v%b l%b rdy%b e%b d=%h want v%b l%b rdy%b e%b d=%h",
                        s, c, ov[c], ol[c], ordy[c], oe[c], ord[c],
                        ev, el, er, ee, ed);
            end
         end
      end
   endtask

   task automatic test_wrap;
      logic ev, el, er, ee;
      logic [31:0] ed;
      bit dk;
      ops.delete();
      ops.push_back('{1'b1, 32'h000, 32'h12345678});
      ops.push_back('{1'b1, 32'h3FC, 32'h0000CAFE});
      ops.push_back('{1'b1, 32'h400, 32'h00000005});
      ops.push_back('{1'b0, 32'h000, 32'h0});
      ops.push_back('{1'b1, 32'h003, 32'h00000077});
      ops.push_back('{1'b0, 32'h000, 32'h0});
      ops.push_back('{1'b0, 32'hFFFFFFFC, 32'h0});
      ops.push_back('{1'b0, 32'h3FC, 32'h0});
      foreach (ops[i]) begin
         drive(0, ops[i].we, ops[i].addr, ops[i].wd,
               1'b0, 1'b0, 32'h0, 32'h0);
         if (ops[i].we) model_write(0, ops[i].addr, ops[i].wd);
         for (int c = 0; c < MAXC; c++) begin
            expect_at(0, ops[i].we, ops[i].addr, c, ev, el, er, ee, ed, dk);
            checks++;
            if (ov[c] !== ev || ol[c] !== el || ordy[c] !== er ||
                oe[c] !== ee || (dk && ord[c] !== ed)) begin
               errors++;
               $display("FAIL wrap op%0d c%0d: got v%b l%b rdy%b e%b d=%h want v%b l%b rdy%b e%b d=%h",
                        i, c, ov[c], ol[c], ordy[c], oe[c], ord[c],
                        ev, el, er, ee, ed);
            end
         end
      end
   endtask

   task automatic test_latency1;
      logic ev, el, er, ee;
      logic [31:0] ed;
      bit dk;
      ops.delete();
      ops.push_back('{1'b1, 32'h10, 32'hA5A5A5A5});
      ops.push_back('{1'b1, 32'h14, 32'h5A5A5A5A});
      ops.push_back('{1'b0, 32'h14, 32'h0});
      add_random(25);
      foreach (ops[i]) begin
         drive(2, ops[i].we, ops[i].addr, ops[i].wd,
               1'b0, 1'b0, 32'h0, 32'h0);
         if (ops[i].we) model_write(2, ops[i].addr, ops[i].wd);
         for (int c = 0; c < MAXC; c++) begin
            expect_at(2, ops[i].we, ops[i].addr, c, ev, el, er, ee, ed, dk);
            checks++;
            if (ov[c] !== ev || ol[c] !== el || ordy[c] !== er ||
                oe[c] !== ee || (dk && ord[c] !== ed)) begin
               errors++;
               $display("FAIL latency1 op%0d c%0d: got v%b l%b rdy%b e%b d=%h want v%b l%b rdy%b e%b d=%h",
                        i, c, ov[c], ol[c], ordy[c], oe[c], ord[c],
                        ev, el, er, ee, ed);
            end
         end
      end
   endtask

   initial begin
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      test_reset();
      test_write_read();
      test_burst();
      test_back_to_back();
      test_wrap();
      test_latency1();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, errors=%0d",
               errors);
      $fatal(1);
   end

endmodule
